// File: rtl/fdivsqrt_sd_encoder.sv
// ---------------------------------------------------------------------------
// fdivsqrt_sd_encoder
//
// Purpose:
//   Recodes an unsigned N-bit operand into N+1 signed digits d_N..d_0, each
//   in {-1,0,+1}, so that X = sum(d_i * 2^i). The digits are streamed out
//   MSB-first over a valid/ready handshake.
//   Two encodings are selectable per operand:
//     - non-adjacent form (Naf=1)
//     - plain binary digits (Naf=0)
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset
//   LoadValid   an operand is offered this cycle
//   LoadReady   the block accepts an operand this cycle (idle)
//   X           unsigned operand, N bits
//   Naf         encoding select, sampled together with X
//   Flush       abort any stream in progress; takes effect at the next edge
//   DigitValid  a digit is presented this cycle
//   DigitReady  the consumer takes the presented digit this cycle
//   up / un     the presented digit is +1 / -1 (both low means 0)
//   DigitIdx    weight index of the presented digit
//   Last        the presented digit is d0
// ---------------------------------------------------------------------------
module fdivsqrt_sd_encoder #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   LoadValid,
    output logic                   LoadReady,
    input  logic [N-1:0]           X,
    input  logic                   Naf,
    input  logic                   Flush,
    output logic                   DigitValid,
    input  logic                   DigitReady,
    output logic                   up,
    output logic                   un,
    output logic [$clog2(N+1)-1:0] DigitIdx,
    output logic                   Last
);

    localparam int IW = $clog2(N+1);
    localparam logic [IW-1:0] TOPIDX = IW'(N);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state;
    state_t nextstate;

    logic [N+1:0] triple;
    logic [N+1:0] single;
    logic [N+1:0] diff;
    logic [N+1:0] pfull;
    logic [N+1:0] mfull;
    logic [N:0]   pload;
    logic [N:0]   mload;
    logic [N:0]   pvec;
    logic [N:0]   mvec;
    logic [IW-1:0] idx;
    logic         accept;
    logic         take;

    // Digit recoding of the offered operand.
    //
    // Non-adjacent form uses the carry trick on 3X against X:
    //   - bits where 3X and X differ mark a nonzero digit;
    //   - the sign of that digit comes from whichever of the two has the bit set.
    // Both quantities are twice the classic 3X/2 and X/2 pair, which is why
    // digit i is read from bit i+1 and bit 0 is dropped.
    //
    // Plain binary just copies X, with a zero top digit.
    always_comb begin
        triple = {2'b00, X} + {1'b0, X, 1'b0};
        single = {2'b00, X};
        diff   = triple ^ single;
        pfull  = diff & triple;
        mfull  = diff & single;
        if (Naf) begin
            pload = pfull[N+1:1];
            mload = mfull[N+1:1];
        end else begin
            pload = {1'b0, X};
            mload = '0;
        end
    end

    // An operand is taken only while idle. A digit moves only on a real
    // handshake while emitting.
    always_comb begin
        accept = (state == IDLE) && LoadValid;
        take   = (state == EMIT) && DigitReady;
    end

    // State register. Reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextstate;
        end
    end

    // Next-state logic.
    // Flush is checked last so that it overrides a coincident load or a
    // coincident final handshake.
    always_comb begin
        nextstate = state;
        case (state)
            IDLE: begin
                if (LoadValid) begin
                    nextstate = EMIT;
                end
            end
            EMIT: begin
                if (DigitReady && (idx == '0)) begin
                    nextstate = IDLE;
                end
            end
            default: begin
                nextstate = IDLE;
            end
        endcase
        if (Flush) begin
            nextstate = IDLE;
        end
    end

    // Digit vectors and the index pointer.
    //
    // The index counts down from N. It parks at 0 after the final digit, so it
    // reads 0 whenever the block is idle. While the consumer stalls, the index
    // and the vectors hold, which keeps every digit output stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pvec <= '0;
            mvec <= '0;
            idx  <= '0;
        end else if (Flush) begin
            idx <= '0;
        end else if (accept) begin
            pvec <= pload;
            mvec <= mload;
            idx  <= TOPIDX;
        end else if (take && (idx != '0)) begin
            idx <= idx - 1'b1;
        end
    end

    // Presentation of the current digit.
    // Everything is gated by DigitValid, so the sign flags are quiet while idle.
    always_comb begin
        LoadReady  = (state == IDLE);
        DigitValid = (state == EMIT);
        up         = DigitValid & pvec[idx];
        un         = DigitValid & mvec[idx];
        DigitIdx   = idx;
        Last       = DigitValid && (idx == '0);
    end

endmodule

// File: tb/tb_fdivsqrt_sd_encoder.sv
// ---------------------------------------------------------------------------
// tb_fdivsqrt_sd_encoder
//
// Purpose:
//   Self-checking bench for fdivsqrt_sd_encoder with N=8. Expected digits
//   come from a textbook NAF recoding loop (or the operand's bits for plain
//   binary). Each presented digit is compared against that, and each
//   stream's digits are summed back to the operand.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_fdivsqrt_sd_encoder;

    localparam int N = 8;

    logic                   clk;
    logic                   reset;
    logic                   LoadValid;
    logic                   LoadReady;
    logic [N-1:0]           X;
    logic                   Naf;
    logic                   Flush;
    logic                   DigitValid;
    logic                   DigitReady;
    logic                   up;
    logic                   un;
    logic [$clog2(N+1)-1:0] DigitIdx;
    logic                   Last;

    int total;
    int bad;
    int expd [0:N];

    fdivsqrt_sd_encoder #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadValid  (LoadValid),
        .LoadReady  (LoadReady),
        .X          (X),
        .Naf        (Naf),
        .Flush      (Flush),
        .DigitValid (DigitValid),
        .DigitReady (DigitReady),
        .up         (up),
        .un         (un),
        .DigitIdx   (DigitIdx),
        .Last       (Last)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a wedged design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, and on a miss count it and report it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference digits.
    //
    // NAF uses the classic right-to-left recoding:
    //   - for an odd value, pick the digit 2 - (v mod 4), which is +1 or -1;
    //   - subtract that digit, then halve.
    // Plain binary digits are just the operand's bits.
    task automatic computeDigits(input int xval, input bit naf);
        int v;
        int d;
        v = xval;
        for (int i = 0; i <= N; i++) begin
            if (naf) begin
                d = (v % 2 != 0) ? 2 - (v % 4) : 0;
                expd[i] = d;
                v = (v - d) / 2;
            end else begin
                expd[i] = (i < N) ? ((xval >> i) & 1) : 0;
            end
        end
    endtask

    // Offer one operand while idle. The design takes it at the next edge.
    task automatic applyStimulus(input int xval, input bit naf);
        logic [31:0] xv;
        computeDigits(xval, naf);
        checkOutput("load_ready", 32'(LoadReady), 32'd1);
        xv        = xval;
        LoadValid = 1'b1;
        X         = xv[N-1:0];
        Naf       = naf;
        @(posedge clk);
        #1;
        LoadValid = 1'b0;
        X         = N'($urandom);
    endtask

    // Drain one stream and check every presented digit.
    //
    // Ready modes:
    //   0 = always ready
    //   1 = toggling 1,0,1,...
    //   2 = random
    // junk:      keep offering 0x55 while the stream runs.
    // abortAt:   index at which to abort the stream; -1 means never.
    // abortKind: 1 = abort with Flush, 2 = abort with reset.
    task automatic consume(input int mode, input bit junk, input int abortAt, input int abortKind,
                           input int xval, input bit naf, output int cycles);
        int k;
        int budget;
        int sum;
        int prev;
        int cur;
        int adj;
        bit rdy;
        bit tog;
        k      = N;
        cycles = 0;
        budget = 200;
        sum    = 0;
        prev   = 0;
        adj    = 0;
        tog    = 1'b1;
        while (k >= 0 && budget > 0) begin
            checkOutput("digit_valid", 32'(DigitValid), 32'd1);
            checkOutput("load_ready_busy", 32'(LoadReady), 32'd0);
            checkOutput("digit_idx", 32'(DigitIdx), 32'(k));
            checkOutput("digit_up", 32'(up), 32'(expd[k] == 1));
            checkOutput("digit_un", 32'(un), 32'(expd[k] == -1));
            checkOutput("digit_last", 32'(Last), 32'(k == 0));
            cur = up ? 1 : (un ? -1 : 0);
            if (abortAt == k) begin
                DigitReady = 1'b1;
                if (abortKind == 1) begin
                    Flush = 1'b1;
                end else begin
                    reset = 1'b1;
                end
                @(posedge clk);
                #1;
                Flush      = 1'b0;
                reset      = 1'b0;
                DigitReady = 1'b0;
                checkOutput("abort_ready", 32'(LoadReady), 32'd1);
                checkOutput("abort_valid", 32'(DigitValid), 32'd0);
                checkOutput("abort_up", 32'(up), 32'd0);
                checkOutput("abort_un", 32'(un), 32'd0);
                checkOutput("abort_last", 32'(Last), 32'd0);
                if (abortKind == 2) begin
                    checkOutput("abort_idx", 32'(DigitIdx), 32'd0);
                end
                @(posedge clk);
                #1;
                checkOutput("abort_quiet", 32'(DigitValid), 32'd0);
                cycles = -1;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1: begin
                    rdy = tog;
                    tog = ~tog;
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            DigitReady = rdy;
            if (junk) begin
                LoadValid = 1'b1;
                X         = 8'h55;
                Naf       = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            budget--;
            if (rdy) begin
                sum += cur * (1 << k);
                if (prev != 0 && cur != 0) begin
                    adj++;
                end
                prev = cur;
                k--;
            end
        end
        DigitReady = 1'b0;
        LoadValid  = 1'b0;
        checkOutput("stream_done", 32'(k < 0), 32'd1);
        checkOutput("digit_sum", 32'(sum), 32'(xval));
        if (naf) begin
            checkOutput("naf_adjacent", 32'(adj), 32'd0);
        end
        checkOutput("end_ready", 32'(LoadReady), 32'd1);
        checkOutput("end_valid", 32'(DigitValid), 32'd0);
        checkOutput("end_up", 32'(up), 32'd0);
        checkOutput("end_un", 32'(un), 32'd0);
        checkOutput("end_last", 32'(Last), 32'd0);
        if (k >= 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    // Directed sequence followed by randomized streams.
    initial begin
        int cyc;
        int xr;
        bit nr;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        LoadValid  = 1'b1;
        X          = 8'h99;
        Naf        = 1'b1;
        Flush      = 1'b0;
        DigitReady = 1'b1;

        // Reset with a load offered at the same time: stays idle.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(LoadReady), 32'd1);
        checkOutput("rst_valid", 32'(DigitValid), 32'd0);
        checkOutput("rst_up", 32'(up), 32'd0);
        checkOutput("rst_un", 32'(un), 32'd0);
        checkOutput("rst_last", 32'(Last), 32'd0);
        checkOutput("rst_idx", 32'(DigitIdx), 32'd0);
        reset      = 1'b0;
        LoadValid  = 1'b0;
        DigitReady = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] 0x07 naf, ready held high");
        applyStimulus(8'h07, 1'b1);
        consume(0, 1'b0, -1, 0, 8'h07, 1'b1, cyc);
        checkOutput("cycles_07", 32'(cyc), 32'd9);

        $display("[TB] 0xA5 plain binary");
        applyStimulus(8'hA5, 1'b0);
        consume(0, 1'b0, -1, 0, 8'hA5, 1'b0, cyc);

        $display("[TB] 0xFF naf, toggling ready");
        applyStimulus(8'hFF, 1'b1);
        consume(1, 1'b0, -1, 0, 8'hFF, 1'b1, cyc);
        checkOutput("cycles_ff", 32'(cyc), 32'd17);

        $display("[TB] 0x00 with a load offered mid-stream");
        applyStimulus(8'h00, 1'b1);
        consume(0, 1'b1, -1, 0, 8'h00, 1'b1, cyc);
        @(posedge clk);
        #1;
        checkOutput("junk_not_taken", 32'(DigitValid), 32'd0);

        $display("[TB] 0x3C flushed at index 5, then 0x01 naf");
        applyStimulus(8'h3C, 1'b0);
        consume(0, 1'b0, 5, 1, 8'h3C, 1'b0, cyc);
        applyStimulus(8'h01, 1'b1);
        consume(0, 1'b0, -1, 0, 8'h01, 1'b1, cyc);

        $display("[TB] flush coincident with a load while idle");
        Flush     = 1'b1;
        LoadValid = 1'b1;
        X         = 8'h12;
        @(posedge clk);
        #1;
        Flush     = 1'b0;
        LoadValid = 1'b0;
        checkOutput("flush_over_load", 32'(LoadReady), 32'd1);

        $display("[TB] reset in the middle of a stream");
        applyStimulus(8'hC3, 1'b1);
        consume(0, 1'b0, 6, 2, 8'hC3, 1'b1, cyc);

        $display("[TB] random operands with random backpressure");
        for (int i = 0; i < 24; i++) begin
            xr = $urandom_range(0, 255);
            nr = (i >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(xr, nr);
            consume(2, 1'b0, -1, 0, xr, nr, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
